// File: rtl/i2c_slave_regif_if.sv
// Register-file side of the I2C target: pointer, write strobe/data,
// read strobe and combinational read data.
interface i2c_slave_regif_if;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic       reg_re_o;
  logic [7:0] reg_rdata_i;

  modport slave (
    output reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
    input  reg_rdata_i
  );

  modport master (
    input  reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
    output reg_rdata_i
  );
endinterface

// File: rtl/i2c_slave_regif.sv
// I2C target exposing an 8-bit-addressed register file.
// Filtered SCL/SDA, open-drain SDA changed only on SCL fall.
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2C,
  parameter int         FILT_LEN   = 3
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic sda_pad_o,
  output logic sda_padoen_o,
  output logic busy_o,
  output logic wr_done_o,
  i2c_slave_regif_if.slave rif
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [1:0]    scl_sync_q, scl_sync_d;
  logic [1:0]    sda_sync_q, sda_sync_d;
  logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d;
  logic [CW-1:0] sda_cnt_q, sda_cnt_d;
  logic          scl_prev_q, sda_prev_q;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       oen_q, oen_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       inc_q, inc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wrote_q, wrote_d;

  logic scl_rise, scl_fall, start, stop, load;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_pad_i};
    sda_sync_d = {sda_sync_q[0], sda_pad_i};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    scl_cnt_d  = '0;
    sda_cnt_d  = '0;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == CW'(FILT_LEN - 1)) scl_f_d = ~scl_f_q;
      else scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == CW'(FILT_LEN - 1)) sda_f_d = ~sda_f_q;
      else sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  assign scl_rise = scl_f_q & ~scl_prev_q;
  assign scl_fall = ~scl_f_q & scl_prev_q;
  assign start = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    ptr_d    = inc_q ? ptr_q + 8'd1 : ptr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    oen_d    = oen_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    inc_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrote_d  = wrote_q;
    load     = 1'b0;
    if (start) begin
      state_d  = ADDR;
      bitcnt_d = 4'd0;
      oen_d    = 1'b1;
      wrote_d  = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
      done_d  = wrote_q;
      wrote_d = 1'b0;
    end else if (scl_rise) begin
      if (state_q == ADDR || state_q == PTR || state_q == WDATA) begin
        shreg_d  = {shreg_q[6:0], sda_f_q};
        bitcnt_d = bitcnt_q + 4'd1;
      end
      if (state_q == RDATA_ACK) ack_d = sda_f_q;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (bitcnt_q == 4'd8) begin
          bitcnt_d = 4'd0;
          // address 0 (general call) is never acknowledged
          if (shreg_q[7:1] == SLAVE_ADDR && SLAVE_ADDR != 7'd0) begin
            oen_d   = 1'b0;
            rw_d    = shreg_q[0];
            busy_d  = 1'b1;
            state_d = ADDR_ACK;
          end else begin
            busy_d  = 1'b0;
            state_d = IGNORE;
          end
        end
        ADDR_ACK: if (rw_q) load = 1'b1;
        else begin
          oen_d    = 1'b1;
          bitcnt_d = 4'd0;
          state_d  = PTR;
        end
        PTR: if (bitcnt_q == 4'd8) begin
          ptr_d   = shreg_q;
          oen_d   = 1'b0;
          state_d = PTR_ACK;
        end
        WDATA: if (bitcnt_q == 4'd8) begin
          wdata_d = shreg_q;
          we_d    = 1'b1;
          inc_d   = 1'b1;
          wrote_d = 1'b1;
          oen_d   = 1'b0;
          state_d = WDATA_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          oen_d    = 1'b1;
          bitcnt_d = 4'd0;
          state_d  = WDATA;
        end
        RDATA: if (bitcnt_q == 4'd7) begin
          oen_d   = 1'b1;
          state_d = RDATA_ACK;
        end else begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          oen_d    = shreg_q[6];
          bitcnt_d = bitcnt_q + 4'd1;
        end
        RDATA_ACK: if (!ack_q) load = 1'b1;
        else state_d = IGNORE;
        default: ;
      endcase
    end
    // pointer bumps the cycle after the strobe so the address holds
    if (load) begin
      shreg_d  = rif.reg_rdata_i;
      re_d     = 1'b1;
      inc_d    = 1'b1;
      oen_d    = rif.reg_rdata_i[7];
      bitcnt_d = 4'd0;
      state_d  = RDATA;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= 4'd0;
      shreg_q    <= 8'd0;
      ptr_q      <= 8'd0;
      wdata_q    <= 8'd0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      oen_q      <= 1'b1;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      inc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrote_q    <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      oen_q      <= oen_d;
      we_q       <= we_d;
      re_q       <= re_d;
      inc_q      <= inc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrote_q    <= wrote_d;
    end
  end

  assign sda_pad_o       = 1'b0;
  assign sda_padoen_o    = oen_q;
  assign busy_o          = busy_q;
  assign wr_done_o       = done_q;
  assign rif.reg_addr_o  = ptr_q;
  assign rif.reg_wdata_o = wdata_q;
  assign rif.reg_we_o    = we_q;
  assign rif.reg_re_o    = re_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, strobe scoreboard.
// Register file model returns addr ^ 8'h5A.
module tb_i2c_slave_regif;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_pad_o, sda_padoen_o, busy, wr_done;
  logic sda_bus;
  logic drv_seen = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];

  i2c_slave_regif_if rif ();

  assign sda_bus = sda_m & sda_padoen_o;
  assign rif.reg_rdata_i = rif.reg_addr_o ^ 8'h5A;

  i2c_slave_regif #(.SLAVE_ADDR(7'h2C), .FILT_LEN(3)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .scl_pad_i   (scl_m),
    .sda_pad_i   (sda_bus),
    .sda_pad_o   (sda_pad_o),
    .sda_padoen_o(sda_padoen_o),
    .busy_o      (busy),
    .wr_done_o   (wr_done),
    .rif         (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] a,
                      input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic sb_take(input int k, input logic [7:0] a,
                         input logic [7:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got strobe kind %0d addr %0h expected none",
               k, a);
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", k, e.kind);
      if (k != 2) chk("sb_addr", a, e.addr);
      if (k == 0) chk("sb_wdata", d, e.data);
    end
  endtask

  // monitor: every strobe must match the head of the expectation queue
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rif.reg_we_o) sb_take(0, rif.reg_addr_o, rif.reg_wdata_o);
      if (rif.reg_re_o) sb_take(1, rif.reg_addr_o, 8'h00);
      if (wr_done) sb_take(2, 8'h00, 8'h00);
    end
    if (!sda_padoen_o) drv_seen = 1'b1;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, input int g, output logic s);
    sda_m = b;
    wclk(10);
    scl_m = 1'b1;
    wclk(5);
    if (g == 1) begin
      scl_m = 1'b0;
      wclk(2);
      scl_m = 1'b1;
    end else if (g == 2) begin
      sda_m = 1'b0;
      wclk(1);
      sda_m = b;
    end
    wclk(5);
    s = sda_bus;
    wclk(10);
    scl_m = 1'b0;
    wclk(10);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wclk(10);
    scl_m = 1'b1;
    wclk(10);
    sda_m = 1'b0;
    wclk(10);
    scl_m = 1'b0;
    wclk(10);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wclk(10);
    scl_m = 1'b1;
    wclk(10);
    sda_m = 1'b1;
    wclk(10);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int gpos,
                         input int gmode, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--)
      i2c_bit(d[i], (7 - i == gpos) ? gmode : 0, s);
    i2c_bit(1'b1, 0, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, 0, s);
      d = {d[6:0], s};
    end
    i2c_bit(nack, 0, s);
  endtask

  initial begin
    logic ack;
    logic s;
    logic [7:0] rd;

    // reset values
    wclk(4);
    chk("rst_oen", sda_padoen_o, 1'b1);
    chk("rst_pad_o", sda_pad_o, 1'b0);
    chk("rst_addr", rif.reg_addr_o, 8'h00);
    chk("rst_wdata", rif.reg_wdata_o, 8'h00);
    chk("rst_we", rif.reg_we_o, 1'b0);
    chk("rst_re", rif.reg_re_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", wr_done, 1'b0);
    rst = 1'b0;
    wclk(20);

    // write burst
    push(0, 8'h10, 8'hA5);
    push(0, 8'h11, 8'h3C);
    push(2, 8'h00, 8'h00);
    i2c_start();
    wr_byte(8'h58, -1, 0, ack);
    chk("wb_ack_addr", ack, 1'b1);
    chk("wb_busy", busy, 1'b1);
    wr_byte(8'h10, -1, 0, ack);
    chk("wb_ack_ptr", ack, 1'b1);
    wr_byte(8'hA5, -1, 0, ack);
    chk("wb_ack_d0", ack, 1'b1);
    wr_byte(8'h3C, -1, 0, ack);
    chk("wb_ack_d1", ack, 1'b1);
    i2c_stop();
    wclk(20);
    chk("wb_ptr", rif.reg_addr_o, 8'h12);
    chk("wb_busy_end", busy, 1'b0);

    // combined read across pointer wrap
    push(1, 8'hFF, 8'h00);
    push(1, 8'h00, 8'h00);
    i2c_start();
    wr_byte(8'h58, -1, 0, ack);
    chk("rd_ack_addr", ack, 1'b1);
    wr_byte(8'hFF, -1, 0, ack);
    chk("rd_ack_ptr", ack, 1'b1);
    i2c_start();
    wr_byte(8'h59, -1, 0, ack);
    chk("rd_ack_addr_r", ack, 1'b1);
    chk("rd_busy", busy, 1'b1);
    rd_byte(1'b0, rd);
    chk("rd_byte0", rd, 8'hA5);
    rd_byte(1'b1, rd);
    chk("rd_byte1", rd, 8'h5A);
    wclk(10);
    chk("rd_released", sda_padoen_o, 1'b1);
    i2c_stop();
    wclk(20);
    chk("rd_ptr", rif.reg_addr_o, 8'h01);
    chk("rd_busy_end", busy, 1'b0);

    // address mismatch
    drv_seen = 1'b0;
    i2c_start();
    wr_byte(8'h5A, -1, 0, ack);
    chk("mm_nack", ack, 1'b0);
    chk("mm_busy", busy, 1'b0);
    wr_byte(8'h00, -1, 0, ack);
    i2c_stop();
    wclk(20);
    chk("mm_no_drive", drv_seen, 1'b0);

    // STOP in the middle of a data byte
    i2c_start();
    wr_byte(8'h58, -1, 0, ack);
    chk("sm_ack_addr", ack, 1'b1);
    wr_byte(8'h20, -1, 0, ack);
    chk("sm_ack_ptr", ack, 1'b1);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, 0, s);
    i2c_stop();
    wclk(20);
    chk("sm_busy", busy, 1'b0);
    chk("sm_ptr", rif.reg_addr_o, 8'h20);

    // glitches on SCL and SDA inside data bytes
    push(0, 8'h30, 8'h81);
    push(0, 8'h31, 8'hC3);
    push(2, 8'h00, 8'h00);
    i2c_start();
    wr_byte(8'h58, -1, 0, ack);
    wr_byte(8'h30, -1, 0, ack);
    wr_byte(8'h81, 0, 1, ack);
    chk("gl_ack_scl", ack, 1'b1);
    wr_byte(8'hC3, 1, 2, ack);
    chk("gl_ack_sda", ack, 1'b1);
    chk("gl_busy", busy, 1'b1);
    i2c_stop();
    wclk(20);
    chk("gl_ptr", rif.reg_addr_o, 8'h32);

    // reset while the target drives a 0 data bit
    push(1, 8'h00, 8'h00);
    i2c_start();
    wr_byte(8'h58, -1, 0, ack);
    wr_byte(8'h00, -1, 0, ack);
    i2c_start();
    wr_byte(8'h59, -1, 0, ack);
    chk("rm_driving", sda_padoen_o, 1'b0);
    rst = 1'b1;
    wclk(1);
    chk("rm_oen", sda_padoen_o, 1'b1);
    chk("rm_addr", rif.reg_addr_o, 8'h00);
    chk("rm_busy", busy, 1'b0);
    chk("rm_we", rif.reg_we_o, 1'b0);
    chk("rm_re", rif.reg_re_o, 1'b0);
    wclk(2);
    rst = 1'b0;
    i2c_stop();
    wclk(20);
    chk("rm_idle_busy", busy, 1'b0);

    wclk(50);
    chk("sb_left", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
